// File: rtl/ball_engine.sv
// Ball-motion engine for the brick playfield.
// Moves one cell diagonally per accepted step, bounces off walls and blocked
// cells, reports struck bricks, and runs the serve / miss / lives sequence.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_SERVE | ball parked at the start cell, waiting for launch
// S_MOVE  | ball in flight, one move or bounce per step
// S_OVER  | no lives left, outputs frozen until reset
module ball_engine #(
  parameter int         ROWS        = 12,
  parameter int         COLS        = 16,
  parameter int         START_ROW   = 9,
  parameter int         START_COL   = 9,
  parameter logic [1:0] START_DIR   = 2'b00,
  parameter int         LIVES       = 3,
  parameter bit         BOTTOM_OPEN = 1'b1,
  localparam int        RW          = $clog2(ROWS),
  localparam int        CW          = $clog2(COLS),
  localparam int        IW          = $clog2(ROWS * COLS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 launch,
  input  logic [ROWS*COLS-1:0] data,
  output logic [RW-1:0]        ball_row,
  output logic [CW-1:0]        ball_col,
  output logic [1:0]           ball_dir,
  output logic                 hit_valid,
  output logic [IW-1:0]        hit_index,
  output logic                 miss,
  output logic [2:0]           lives_left,
  output logic                 game_over
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_MOVE  = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] HOME_ROW  = RW'(START_ROW);
  localparam logic [CW-1:0] HOME_COL  = CW'(START_COL);
  localparam logic [2:0]    ALL_LIVES = 3'(LIVES);
  localparam logic [IW-1:0] COLS_I    = IW'(COLS);
  localparam logic [RW:0]   ROW_ONE   = (RW+1)'(1);
  localparam logic [CW:0]   COL_ONE   = (CW+1)'(1);

  state_t          state, state_d;
  logic [RW-1:0]   row_d;
  logic [CW-1:0]   col_d;
  logic [1:0]      dir_d;
  logic [2:0]      lives_d;
  logic            hit_valid_d, miss_d, game_over_d;
  logic [IW-1:0]   hit_index_d;

  // Neighbour coordinates carry one extra bit: 0-1 sets the MSB and one past
  // the last row/column either sets the MSB or exceeds the limit, so a step
  // off the grid can never alias onto a real cell.
  logic [RW:0]     row_x, v_row;
  logic [CW:0]     col_x, h_col;
  logic            v_in, h_in, d_in;
  logic [IW-1:0]   v_idx, h_idx, d_idx;
  logic            v_blk, h_blk, d_blk;
  logic            v_brick, h_brick, d_brick;
  logic            pit;

  assign row_x = {1'b0, ball_row};
  assign col_x = {1'b0, ball_col};
  assign v_row = ball_dir[1] ? row_x + ROW_ONE : row_x - ROW_ONE;
  assign h_col = ball_dir[0] ? col_x + COL_ONE : col_x - COL_ONE;

  assign v_in = !v_row[RW] && (v_row[RW-1:0] <= LAST_ROW);
  assign h_in = !h_col[CW] && (h_col[CW-1:0] <= LAST_COL);
  assign d_in = v_in && h_in;

  assign v_idx = IW'(v_row[RW-1:0]) * COLS_I + IW'(ball_col);
  assign h_idx = IW'(ball_row) * COLS_I + IW'(h_col[CW-1:0]);
  assign d_idx = IW'(v_row[RW-1:0]) * COLS_I + IW'(h_col[CW-1:0]);

  assign v_brick = v_in && data[v_idx];
  assign h_brick = h_in && data[h_idx];
  assign d_brick = d_in && data[d_idx];
  assign v_blk   = !v_in || v_brick;
  assign h_blk   = !h_in || h_brick;
  assign d_blk   = !d_in || d_brick;

  assign pit = BOTTOM_OPEN && ball_dir[1] && (ball_row == LAST_ROW);

  // Register every output and the FSM state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_SERVE;
      ball_row   <= HOME_ROW;
      ball_col   <= HOME_COL;
      ball_dir   <= START_DIR;
      lives_left <= ALL_LIVES;
      hit_valid  <= 1'b0;
      hit_index  <= '0;
      miss       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      ball_row   <= row_d;
      ball_col   <= col_d;
      ball_dir   <= dir_d;
      lives_left <= lives_d;
      hit_valid  <= hit_valid_d;
      hit_index  <= hit_index_d;
      miss       <= miss_d;
      game_over  <= game_over_d;
    end
  end

  // Next state: serve, one move-or-bounce per step, pit handling.
  always_comb begin
    state_d     = state;
    row_d       = ball_row;
    col_d       = ball_col;
    dir_d       = ball_dir;
    lives_d     = lives_left;
    hit_valid_d = 1'b0;
    hit_index_d = hit_index;
    miss_d      = 1'b0;
    case (state)
      S_SERVE: begin
        if (launch) begin
          state_d = S_MOVE;
          dir_d   = START_DIR;
        end
      end
      S_MOVE: begin
        if (step) begin
          if (pit) begin
            miss_d  = 1'b1;
            lives_d = lives_left - 3'd1;
            row_d   = HOME_ROW;
            col_d   = HOME_COL;
            dir_d   = START_DIR;
            state_d = (lives_left == 3'd1) ? S_OVER : S_SERVE;
          end else if (v_blk || h_blk) begin
            dir_d = {ball_dir[1] ^ v_blk, ball_dir[0] ^ h_blk};
            if (v_brick) begin
              hit_valid_d = 1'b1;
              hit_index_d = v_idx;
            end else if (h_brick) begin
              hit_valid_d = 1'b1;
              hit_index_d = h_idx;
            end
          end else if (d_blk) begin
            dir_d = ~ball_dir;
            if (d_brick) begin
              hit_valid_d = 1'b1;
              hit_index_d = d_idx;
            end
          end else begin
            row_d = v_row[RW-1:0];
            col_d = h_col[CW-1:0];
          end
        end
      end
      default: ;
    endcase
    game_over_d = (state_d == S_OVER);
  end

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: a cell-level reference model follows both a default
// playfield and a small closed-bottom one, a per-cycle compare process checks
// every output, and directed scenarios pin known positions with literals.
module tb_ball_engine;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         step_a = 1'b0, launch_a = 1'b0;
  logic         step_b = 1'b0, launch_b = 1'b0;
  logic [191:0] data_a = '0;
  logic [29:0]  data_b = '0;

  logic [3:0] row_a, col_a;
  logic [1:0] dir_a, dir_b;
  logic       hv_a, miss_a, go_a, hv_b, miss_b, go_b;
  logic [7:0] idx_a;
  logic [2:0] lives_a, lives_b, row_b, col_b;
  logic [4:0] idx_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ball_engine u_a (
    .clock(clock), .reset(reset), .step(step_a), .launch(launch_a), .data(data_a),
    .ball_row(row_a), .ball_col(col_a), .ball_dir(dir_a), .hit_valid(hv_a),
    .hit_index(idx_a), .miss(miss_a), .lives_left(lives_a), .game_over(go_a)
  );

  ball_engine #(
    .ROWS(6), .COLS(5), .START_ROW(3), .START_COL(2), .START_DIR(2'b00),
    .LIVES(3), .BOTTOM_OPEN(1'b0)
  ) u_b (
    .clock(clock), .reset(reset), .step(step_b), .launch(launch_b), .data(data_b),
    .ball_row(row_b), .ball_col(col_b), .ball_dir(dir_b), .hit_valid(hv_b),
    .hit_index(idx_b), .miss(miss_b), .lives_left(lives_b), .game_over(go_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int rows; int cols; bit bopen; int sr; int sc; int sd; int lives;
  } cfg_t;

  // phase: 0 waiting for serve, 1 in flight, 2 out of balls
  typedef struct {
    int phase; int row; int col; int dir; int lives; bit hit; int hidx; bit miss;
  } mdl_t;

  cfg_t cfg_a, cfg_b;
  mdl_t m_a, m_b;
  bit   started = 0;

  function automatic bit on_grid(int r, int c, cfg_t k);
    return (r >= 0) && (c >= 0) && (r < k.rows) && (c < k.cols);
  endfunction

  function automatic bit is_brick(int r, int c, logic [191:0] d, cfg_t k);
    if (!on_grid(r, c, k)) return 1'b0;
    return d[r * k.cols + c];
  endfunction

  function automatic bit is_blocked(int r, int c, logic [191:0] d, cfg_t k);
    return !on_grid(r, c, k) || is_brick(r, c, d, k);
  endfunction

  function automatic mdl_t m_init(cfg_t k);
    mdl_t n;
    n.phase = 0; n.row = k.sr; n.col = k.sc; n.dir = k.sd; n.lives = k.lives;
    n.hit = 0; n.hidx = 0; n.miss = 0;
    return n;
  endfunction

  function automatic mdl_t m_step(mdl_t m, bit stp, bit lch, logic [191:0] d, cfg_t k);
    mdl_t n;
    int dr, dc;
    bit vb, hb, db;
    n = m;
    n.hit = 0;
    n.miss = 0;
    if (m.phase == 0) begin
      if (lch) begin
        n.phase = 1;
        n.dir = k.sd;
      end
    end else if (m.phase == 1 && stp) begin
      dr = (m.dir >= 2) ? 1 : -1;
      dc = (m.dir % 2 == 1) ? 1 : -1;
      if (dr == 1 && m.row == k.rows - 1 && k.bopen) begin
        n.miss = 1;
        n.lives = m.lives - 1;
        n.row = k.sr; n.col = k.sc; n.dir = k.sd;
        n.phase = (n.lives == 0) ? 2 : 0;
      end else begin
        vb = is_blocked(m.row + dr, m.col, d, k);
        hb = is_blocked(m.row, m.col + dc, d, k);
        db = is_blocked(m.row + dr, m.col + dc, d, k);
        if (vb || hb) begin
          if (vb) n.dir = n.dir ^ 2;
          if (hb) n.dir = n.dir ^ 1;
          if (is_brick(m.row + dr, m.col, d, k)) begin
            n.hit = 1; n.hidx = (m.row + dr) * k.cols + m.col;
          end else if (is_brick(m.row, m.col + dc, d, k)) begin
            n.hit = 1; n.hidx = m.row * k.cols + m.col + dc;
          end
        end else if (db) begin
          n.dir = m.dir ^ 3;
          if (is_brick(m.row + dr, m.col + dc, d, k)) begin
            n.hit = 1; n.hidx = (m.row + dr) * k.cols + m.col + dc;
          end
        end else begin
          n.row = m.row + dr;
          n.col = m.col + dc;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model advances on the same edges the DUTs sample.
  always @(posedge clock) begin
    if (reset) begin
      m_a = m_init(cfg_a);
      m_b = m_init(cfg_b);
    end else begin
      m_a = m_step(m_a, step_a, launch_a, data_a, cfg_a);
      m_b = m_step(m_b, step_b, launch_b, 192'(data_b), cfg_b);
    end
    started = 1;
  end

  // Compare every output of both DUTs on every cycle.
  always @(negedge clock) begin
    if (started) begin
      chk("a_row", int'(row_a), m_a.row);
      chk("a_col", int'(col_a), m_a.col);
      chk("a_dir", int'(dir_a), m_a.dir);
      chk("a_lives", int'(lives_a), m_a.lives);
      chk("a_hit_valid", int'(hv_a), int'(m_a.hit));
      chk("a_miss", int'(miss_a), int'(m_a.miss));
      chk("a_game_over", int'(go_a), int'(m_a.phase == 2));
      if (m_a.hit) chk("a_hit_index", int'(idx_a), m_a.hidx);
      chk("b_row", int'(row_b), m_b.row);
      chk("b_col", int'(col_b), m_b.col);
      chk("b_dir", int'(dir_b), m_b.dir);
      chk("b_lives", int'(lives_b), m_b.lives);
      chk("b_hit_valid", int'(hv_b), int'(m_b.hit));
      chk("b_miss", int'(miss_b), int'(m_b.miss));
      chk("b_game_over", int'(go_b), int'(m_b.phase == 2));
      chk("b_row_in_range", int'(row_b <= 3'd5), 1);
      chk("b_col_in_range", int'(col_b <= 3'd4), 1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pos_a(input string nm, input int r, input int c, input int d);
    chk({nm, "_row"}, int'(row_a), r);
    chk({nm, "_col"}, int'(col_a), c);
    chk({nm, "_dir"}, int'(dir_a), d);
  endtask

  task automatic lose_ball(input int lives_after);
    launch_a = 1; tick(1); launch_a = 0;
    step_a = 1; tick(22); step_a = 0;
    chk("miss_pulse", int'(miss_a), 1);
    chk("miss_lives", int'(lives_a), lives_after);
    pos_a("miss_park", 9, 9, 0);
  endtask

  int bottom_bounces;

  initial begin
    cfg_a = '{rows: 12, cols: 16, bopen: 1'b1, sr: 9, sc: 9, sd: 0, lives: 3};
    cfg_b = '{rows: 6, cols: 5, bopen: 1'b0, sr: 3, sc: 2, sd: 0, lives: 3};

    // reset and serve
    tick(2); reset = 0;
    pos_a("reset", 9, 9, 0);
    chk("reset_lives", int'(lives_a), 3);
    chk("reset_game_over", int'(go_a), 0);
    step_a = 1; tick(1); step_a = 0;
    pos_a("step_in_serve", 9, 9, 0);
    launch_a = 1; tick(1); launch_a = 0;
    step_a = 1; tick(1); step_a = 0;
    pos_a("first_move", 8, 8, 0);
    launch_a = 1; tick(1); launch_a = 0;
    pos_a("launch_in_move", 8, 8, 0);

    // vertical brick above the ball
    data_a[120] = 1'b1;
    step_a = 1; tick(1); step_a = 0;
    pos_a("brick_v", 8, 8, 2);
    chk("brick_v_hit", int'(hv_a), 1);
    chk("brick_v_index", int'(idx_a), 120);
    tick(1);
    chk("brick_v_pulse_drop", int'(hv_a), 0);
    data_a = '0;

    // launch and step together: only the launch counts
    reset = 1; tick(1); reset = 0;
    launch_a = 1; step_a = 1; tick(1); launch_a = 0;
    pos_a("launch_and_step", 9, 9, 0);
    tick(1); step_a = 0;
    pos_a("after_launch_step", 8, 8, 0);

    // diagonal-only brick
    data_a[119] = 1'b1;
    step_a = 1; tick(1); step_a = 0;
    pos_a("brick_d", 8, 8, 3);
    chk("brick_d_hit", int'(hv_a), 1);
    chk("brick_d_index", int'(idx_a), 119);
    data_a = '0;

    // corner bounce and first miss, stepping on every clock
    reset = 1; tick(1); reset = 0;
    launch_a = 1; tick(1); launch_a = 0;
    step_a = 1;
    tick(9);  pos_a("reach_corner", 0, 0, 0);
    tick(1);  pos_a("corner_bounce", 0, 0, 3);
    chk("corner_silent", int'(hv_a), 0);
    tick(1);  pos_a("leave_corner", 1, 1, 3);
    tick(10); pos_a("bottom_row", 11, 11, 3);
    tick(1);  step_a = 0;
    chk("miss1_pulse", int'(miss_a), 1);
    chk("miss1_lives", int'(lives_a), 2);
    pos_a("miss1_park", 9, 9, 0);
    tick(1);
    chk("miss1_pulse_drop", int'(miss_a), 0);

    lose_ball(1);
    lose_ball(0);
    chk("game_over_set", int'(go_a), 1);

    // OVER ignores launch and step
    launch_a = 1; step_a = 1; tick(5); launch_a = 0; step_a = 0;
    pos_a("over_frozen", 9, 9, 0);
    chk("over_lives", int'(lives_a), 0);
    chk("over_game_over", int'(go_a), 1);

    // reset leaves OVER; reset mid-flight beats step
    reset = 1; tick(1); reset = 0;
    chk("reset_from_over", int'(go_a), 0);
    chk("reset_lives_restored", int'(lives_a), 3);
    launch_a = 1; tick(1); launch_a = 0;
    step_a = 1; tick(3);
    pos_a("midflight", 6, 6, 0);
    reset = 1; tick(1); reset = 0; step_a = 0;
    pos_a("reset_midflight", 9, 9, 0);

    // small closed-bottom grid
    launch_b = 1; tick(1); launch_b = 0;
    step_b = 1;
    bottom_bounces = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (row_b == 3'd5 && dir_b[1] == 1'b0 && !hv_b) bottom_bounces++;
    end
    step_b = 0;
    chk("b_bottom_wall_seen", int'(bottom_bounces > 0), 1);
    chk("b_lives_kept", int'(lives_b), 3);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball-motion engine for the brick playfield. It generalises the fixed 12×16 ball mover with configurable grid size, start position and direction, and a step enable that decouples motion speed from the clock. It adds a launch/serve state machine, an open-bottom miss rule with a lives counter, and a per-step brick-hit report. The brick-clearing logic consumes the hit report, and the display path consumes the ball position.

## Interface
- ROWS, 12, playfield rows; row 0 is the top.
- COLS, 16, playfield columns.
- START_ROW, 9, row where the ball is parked when served.
- START_COL, 9, column where the ball is parked when served.
- START_DIR, 2'b00, direction at launch.
- LIVES, 3, balls per game; range 1..7.
- BOTTOM_OPEN, 1, 1: the row below ROWS-1 is a pit; 0: it is a wall.
- RW = $clog2(ROWS), CW = $clog2(COLS), IW = $clog2(ROWS*COLS) (derived, not overridable).

Ports:
- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- step  in  1  advance the ball one cell-time; ignored unless in MOVE.
- launch  in  1  serve the ball from SERVE.
- data  in  ROWS*COLS  occupancy map; bit r*COLS+c = 1 means cell (r,c) is blocked.
- ball_row  out  RW  current row.
- ball_col  out  CW  current column.
- ball_dir  out  2  bit1 = 1 moving down (row+1), bit0 = 1 moving toward col+1.
- hit_valid  out  1  one-cycle pulse: a blocked in-grid cell was struck.
- hit_index  out  IW  r*COLS+c of the struck cell; valid only with hit_valid.
- miss  out  1  one-cycle pulse: the ball fell into the pit.
- lives_left  out  3  remaining balls.
- game_over  out  1  high while in OVER.

## Operation
- **States:** SERVE, MOVE, OVER.
- **Reset:** state SERVE, ball_row=START_ROW, ball_col=START_COL, ball_dir=START_DIR, lives_left=LIVES. hit_valid, miss and game_over are 0.
- **SERVE:** the ball stays parked. When launch=1, go to MOVE with ball_dir=START_DIR.
- **MOVE, on step=1:** let dr=±1 and dc=±1 come from ball_dir. Define:
  - V = (row+dr, col)
  - H = (row, col+dc)
  - D = (row+dr, col+dc)
- **Out-of-grid cells:** any cell outside the grid counts as blocked. Exception: when BOTTOM_OPEN=1, row ROWS is the pit, not a wall.
- **Arithmetic:** evaluate neighbours in RW+1 / CW+1 bit signed arithmetic, so row 0 − 1 and col 0 − 1 detect out-of-grid. They must never wrap into the grid.
- **Move/bounce priority:**
  1. Pit: moving down, row=ROWS-1, BOTTOM_OPEN=1 → pulse miss, decrement lives_left, park the ball at START. Go to OVER if lives_left becomes 0, else go to SERVE.
  2. V or H blocked → flip bit1 if V is blocked, flip bit0 if H is blocked; the position holds.
  3. Else D blocked → flip both bits; the position holds.
  4. Else → move to D.
- **Hit report:** when a bounce involves an in-grid blocked cell, pulse hit_valid. hit_index selects V, else H, else D.
- **Walls:** walls never produce hits. Bounces from walls only are silent.
- **OVER:** all outputs are frozen and step/launch are ignored; only reset leaves OVER.

## Timing
- All outputs are registered.
- A step sampled high at edge N updates position/direction at edge N, so new values are visible in cycle N+1.
- hit_valid and miss are high for exactly cycle N+1, then drop.
- There is no move-after-bounce within the same step: a bounce consumes the whole step.
- Back-to-back steps on every clock are legal. Each one re-evaluates from the registered position using the current data.
- data must be stable at the sampling edge. The engine does not clear bricks; if data is unchanged, a re-hit of the same cell on a later step is reported again.
- launch while in MOVE is ignored. step while in SERVE is ignored.
- If launch and step are both high in SERVE, only the launch takes effect; the first move needs a later step.
- reset mid-flight wins over every other input and takes effect at that edge.

## Test plan
- **Reset/serve:** reset high 1 cycle → row=9, col=9, dir=00, lives_left=3. Pulse step without launch → position unchanged. Pulse launch, then step → row=8, col=8 (dir 00 = up, col−1).
- **Corner bounce:** empty data; place the ball at (0,0) moving up/col−1; pulse step → dir=11, position unchanged, hit_valid=0. The next step moves to (1,1).
- **Brick hit:** set data bit 7*16+8; ball at (8,8) dir=00 → after the step, dir=10, hit_valid=1 for one cycle, hit_index=120.
- **Diagonal-only hit:** set data bit 7*16+7 with V and H clear → both dir bits flip, hit_index=119.
- **Miss/lives:** ball at (11,5) moving down, BOTTOM_OPEN=1 → miss pulse, lives_left 3→2, state SERVE, ball at (9,9). After three misses, game_over=1 and further launch/step have no effect until reset.
- **Generality:** ROWS=6, COLS=5, BOTTOM_OPEN=0 → run 200 steps on an empty grid. Position stays within 0..5 / 0..4, miss and hit_valid are never asserted, and the bottom row bounces as a wall.
